// File: rtl/tx_byte_queue_pkg.sv
// Shared types and defaults for the UART transmit byte queue.
package tx_byte_queue_pkg;

    localparam int DEF_DEPTH        = 16;
    localparam int DEF_BYTE_GAP     = 434;
    localparam int DEF_BUSY_TIMEOUT = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } tx_state_t;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tx_byte_queue_if.sv
// Byte write side (message_unit) and uart_tx side of the transmit queue.
interface tx_byte_queue_if import tx_byte_queue_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH
);
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     tx_busy;
    logic                     data_send;
    logic [7:0]               data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     timeout_err;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  data_send, data, full, empty, count, overflow, timeout_err
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output data_send, data, full, empty, count, overflow, timeout_err
    );
endinterface

// File: rtl/tx_byte_queue_sync_fifo.sv
// Circular byte buffer; a write into a full buffer is still accepted when a pop happens in the same cycle.
module sync_fifo import tx_byte_queue_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   rd_en,
    output logic [7:0]             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign drop    = wr_en && full && !pop;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; a write during reset is dropped by the rst_n gate.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tx_byte_queue.sv
// Queues bytes from message_unit and launches them one at a time into uart_tx with an enforced inter-byte gap.
module tx_byte_queue import tx_byte_queue_pkg::*; #(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int BYTE_GAP     = DEF_BYTE_GAP,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input logic           clk_50M,
    input logic           rst_n,
    tx_byte_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = cnt_width(BYTE_GAP);
    localparam int TW = cnt_width(BUSY_TIMEOUT);

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    data_q;
    logic          overflow_q;
    logic          timeout_q;
    logic          pop;
    logic          tmo_hit;
    logic          gap_done;
    logic          tmo_done;

    logic [7:0]    rd_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          drop;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk_50M),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .drop    (drop)
    );

    // BYTE_GAP of 0 or 1 both leave after the first GAP cycle.
    assign gap_done = (BYTE_GAP <= 1) ? 1'b1 : (gap_cnt == GW'(BYTE_GAP - 1));
    assign tmo_done = (tmo_cnt == TW'(BUSY_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_done) begin
                    tmo_hit   = 1'b1;
                    state_nxt = GAP;
                end
            end
            WAIT_DONE: if (!bus.tx_busy) state_nxt = GAP;
            GAP:       if (gap_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            tmo_cnt    <= '0;
            data_q     <= 8'h00;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= (state == GAP && state_nxt == GAP) ? gap_cnt + GW'(1) : '0;
            tmo_cnt <= (state == WAIT_BUSY && state_nxt == WAIT_BUSY) ? tmo_cnt + TW'(1) : '0;
            if (pop)     data_q     <= rd_data;
            if (drop)    overflow_q <= 1'b1;
            if (tmo_hit) timeout_q  <= 1'b1;
        end
    end

    assign bus.data_send   = (state == LAUNCH);
    assign bus.data        = data_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_tx_byte_queue.sv
// Bench for tx_byte_queue: vector table, directed corner cases and a randomized run against a queue model.
module tb_tx_byte_queue;
    import tx_byte_queue_pkg::*;

    localparam int DEPTH        = 16;
    localparam int BYTE_GAP     = 434;
    localparam int BUSY_TIMEOUT = 8;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_50M = ~clk_50M;

    tx_byte_queue_if #(.DEPTH(DEPTH)) bus ();

    tx_byte_queue #(
        .DEPTH(DEPTH), .BYTE_GAP(BYTE_GAP), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx stand-in
    typedef enum {U_MANUAL, U_AUTO, U_HIGH, U_LOW} umode_t;
    umode_t umode     = U_MANUAL;
    int     busy_len  = 5208;
    int     busy_left = 0;

    initial forever begin
        @(negedge clk_50M);
        #1;
        case (umode)
            U_HIGH: bus.tx_busy = 1'b1;
            U_LOW:  bus.tx_busy = 1'b0;
            U_AUTO: begin
                if (busy_left > 0) begin
                    busy_left--;
                    bus.tx_busy = (busy_left > 0);
                end else if (bus.data_send) begin
                    busy_left   = busy_len;
                    bus.tx_busy = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reference model: bytes expected out, in order
    logic [7:0] model_q[$];
    bit   sb_en        = 0;
    int   cyc_n        = 0;
    int   n_launch     = 0;
    int   fall_cyc     = 0;
    bit   have_fall    = 0;
    bit   pend_at_fall = 0;
    logic prev_busy    = 1'b0;
    logic prev_send    = 1'b0;

    always @(posedge clk_50M) cyc_n++;

    initial forever begin
        @(negedge clk_50M);
        if (prev_busy && !bus.tx_busy) begin
            fall_cyc     = cyc_n;
            have_fall    = 1;
            pend_at_fall = (model_q.size() > 0);
        end
        prev_busy = bus.tx_busy;
        if (bus.data_send) begin
            n_launch++;
            chk("send_one_cycle", prev_send, 1'b0);
            if (sb_en) begin
                if (model_q.size() == 0) chk("launch_unexpected", 1, 0);
                else chk("launch_data", bus.data, model_q.pop_front());
                if (have_fall) begin
                    chk("gap_min", (cyc_n - fall_cyc - 1 >= BYTE_GAP), 1);
                    if (pend_at_fall) chk("gap_max", (cyc_n - fall_cyc - 1 <= BYTE_GAP + 2), 1);
                    have_fall = 0;
                end
            end
        end
        prev_send = bus.data_send;
        if (sb_en) chk("count_model", bus.count, model_q.size());
    end

    // One clock: drive inputs, return after the edge with outputs settled.
    task automatic cyc(input logic we, input logic [7:0] b);
        bus.wr_en   = we;
        bus.wr_data = b;
        if (we && sb_en) model_q.push_back(b);
        @(negedge clk_50M);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        rst_n = 1'b1;
        have_fall = 0;
        model_q.delete();
    endtask

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       busy;
        logic [4:0] cnt;
        logic       emp;
        logic       ful;
        logic       snd;
        logic [7:0] dat;
    } vec_t;

    vec_t tv[7];

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_busy = 1'b0;
        @(negedge clk_50M);
        #2;

        // Reset state, with a write in the reset cycle that must be ignored
        rst_n = 1'b0;
        cyc(1'b1, 8'hAA);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_send", bus.data_send, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        rst_n = 1'b1;

        // Vector table, tx_busy driven directly
        tv[0] = '{1'b1, 8'h3C, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[1] = '{1'b1, 8'hA5, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[2] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00};
        tv[3] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h3C};
        tv[4] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};
        tv[5] = '{1'b1, 8'h5A, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 8'h3C};
        tv[6] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h3C};
        for (int i = 0; i < 7; i++) begin
            bus.tx_busy = tv[i].busy;
            cyc(tv[i].we, tv[i].wd);
            chk($sformatf("tv%0d_count", i), bus.count, tv[i].cnt);
            chk($sformatf("tv%0d_empty", i), bus.empty, tv[i].emp);
            chk($sformatf("tv%0d_full", i), bus.full, tv[i].ful);
            chk($sformatf("tv%0d_send", i), bus.data_send, tv[i].snd);
            chk($sformatf("tv%0d_data", i), bus.data, tv[i].dat);
        end

        // Single byte latency
        bus.tx_busy = 1'b0;
        do_reset();
        busy_left = 0;
        busy_len  = 20;
        umode     = U_AUTO;
        cyc(1'b1, 8'h46);
        chk("lat_empty_c1", bus.empty, 0);
        chk("lat_send_c1", bus.data_send, 0);
        cyc(1'b0, 8'h00);
        chk("lat_send_c2", bus.data_send, 1);
        chk("lat_data_c2", bus.data, 8'h46);
        chk("lat_count_c2", bus.count, 0);
        for (int i = 0; i < 500; i++) cyc(1'b0, 8'h00);

        // Five bytes against full-length frames
        begin
            string s;
            int n0, w;
            s = "FIM-#";
            do_reset();
            busy_len = 5208;
            sb_en    = 1;
            n0       = n_launch;
            for (int i = 0; i < 5; i++) cyc(1'b1, s[i]);
            w = 0;
            while ((n_launch - n0) < 5 && w < 35000) begin
                cyc(1'b0, 8'h00);
                w++;
            end
            chk("fim_launches", n_launch - n0, 5);
            w = 0;
            while (bus.tx_busy && w < 6000) begin
                cyc(1'b0, 8'h00);
                w++;
            end
            chk("fim_drained", model_q.size(), 0);
            sb_en = 0;
        end

        // Randomized traffic with short frames
        begin
            int w;
            do_reset();
            sb_en = 1;
            for (int i = 0; i < 6000; i++) begin
                busy_len = $urandom_range(3, 30);
                if (model_q.size() < DEPTH - 1 && (i < 10 || $urandom_range(0, 299) == 0))
                    cyc(1'b1, 8'($urandom));
                else
                    cyc(1'b0, 8'h00);
            end
            w = 0;
            while ((model_q.size() > 0 || bus.tx_busy) && w < 20000) begin
                cyc(1'b0, 8'h00);
                w++;
            end
            chk("rand_drained", model_q.size(), 0);
            chk("rand_overflow", bus.overflow, 0);
            chk("rand_timeout", bus.timeout_err, 0);
            sb_en = 0;
        end

        // Overflow with uart held busy
        do_reset();
        umode = U_HIGH;
        cyc(1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i));
        chk("ovf_full16", bus.full, 1);
        chk("ovf_count16", bus.count, 16);
        chk("ovf_flag16", bus.overflow, 0);
        cyc(1'b1, 8'hEE);
        chk("ovf_count17", bus.count, 16);
        chk("ovf_flag17", bus.overflow, 1);
        cyc(1'b0, 8'h00);
        chk("ovf_sticky", bus.overflow, 1);

        // Write into a full queue on the pop cycle
        do_reset();
        cyc(1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i));
        chk("popw_full_before", bus.full, 1);
        umode       = U_MANUAL;
        bus.tx_busy = 1'b0;
        cyc(1'b1, 8'h77);
        bus.tx_busy = 1'b1;
        chk("popw_count", bus.count, 16);
        chk("popw_overflow", bus.overflow, 0);
        chk("popw_send", bus.data_send, 1);
        chk("popw_data", bus.data, 8'h10);
        cyc(1'b0, 8'h00);
        chk("popw_count_after", bus.count, 16);

        // tx_busy never rises
        begin
            int k;
            do_reset();
            umode = U_LOW;
            cyc(1'b1, 8'hC1);
            cyc(1'b1, 8'hC2);
            k = 0;
            while (!bus.data_send && k < 10) begin
                cyc(1'b0, 8'h00);
                k++;
            end
            chk("tmo_launch1", bus.data_send, 1);
            chk("tmo_data1", bus.data, 8'hC1);
            k = 0;
            while (!bus.timeout_err && k < 20) begin
                cyc(1'b0, 8'h00);
                k++;
            end
            chk("tmo_flag", bus.timeout_err, 1);
            chk("tmo_delay", (k >= BUSY_TIMEOUT && k <= BUSY_TIMEOUT + 1), 1);
            k = 0;
            while (!bus.data_send && k < BYTE_GAP + 20) begin
                cyc(1'b0, 8'h00);
                k++;
            end
            chk("tmo_launch2", bus.data_send, 1);
            chk("tmo_data2", bus.data, 8'hC2);
            chk("tmo_gap_min", (k >= BYTE_GAP), 1);
            chk("tmo_sticky", bus.timeout_err, 1);
        end

        // Reset during WAIT_DONE with three bytes queued
        begin
            int n0;
            do_reset();
            busy_left = 0;
            busy_len  = 5208;
            umode     = U_AUTO;
            for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i));
            for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00);
            chk("mid_busy", bus.tx_busy, 1);
            chk("mid_count", bus.count, 3);
            n0    = n_launch;
            rst_n = 1'b0;
            cyc(1'b1, 8'hFF);
            chk("mid_empty", bus.empty, 1);
            chk("mid_count0", bus.count, 0);
            chk("mid_send", bus.data_send, 0);
            chk("mid_data", bus.data, 8'h00);
            rst_n = 1'b1;
            for (int i = 0; i < 6000; i++) cyc(1'b0, 8'h00);
            chk("mid_no_launch", n_launch - n0, 0);
            chk("mid_still_empty", bus.empty, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
